// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32M multiply/divide types and constants
package rv32_pkg;

    localparam int XLEN     = 32;
    localparam int MDU_ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/write-back bundle between decode, register file and the MDU
interface mdu_iter_if import rv32_pkg::*; ();

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [4:0]      add3;
    logic [XLEN-1:0] wd3;
    logic            we3;

    modport master (
        output start, op, rs1_val, rs2_val, rd_in, flush,
        input  busy, valid, add3, wd3, we3
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_in, flush,
        output busy, valid, add3, wd3, we3
    );

endinterface

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - restoring divider on unsigned magnitudes, one quotient bit per step
module mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quot_nxt,
    output logic [XLEN-1:0] o_rem_nxt
);

    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;

    // The dividend shifts out of the quotient register while quotient bits shift in.
    assign w_rem_sh   = {r_rem, r_quot[XLEN-1]};
    assign w_ge       = w_rem_sh >= {1'b0, r_divisor};
    assign o_quot_nxt = {r_quot[XLEN-2:0], w_ge};
    assign o_rem_nxt  = w_ge ? XLEN'(w_rem_sh - {1'b0, r_divisor}) : w_rem_sh[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (i_step) begin
            r_quot    <= o_quot_nxt;
            r_rem     <= o_rem_nxt;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit with one-cycle write-back pulse
// Optional MDU_FAST_MUL_EN: multiplies resolve in a single cycle, divides still iterate.
module mdu_iter import rv32_pkg::*; #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int ITER = rv32_pkg::MDU_ITER
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);

    localparam int              CW    = $clog2(ITER);
    localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    mdu_op_e           r_op;
    logic [4:0]        r_rd;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic              r_busy;
    logic              r_valid;
    logic              r_we3;
    logic [4:0]        r_add3;
    logic [XLEN-1:0]   r_wd3;

    mdu_op_e           w_op;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_accept;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot_nxt;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_calc_res;

    assign w_op     = mdu_op_e'(bus.op);
    assign w_is_div = bus.op[2];
    assign w_accept = (r_state == IDLE) && bus.start && !bus.flush;

    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (w_op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            OP_MULHSU: w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_a_neg = w_a_signed && bus.rs1_val[XLEN-1];
    assign w_b_neg = w_b_signed && bus.rs2_val[XLEN-1];
    assign w_a_mag = w_a_neg ? -bus.rs1_val : bus.rs1_val;
    assign w_b_mag = w_b_neg ? -bus.rs2_val : bus.rs2_val;

    // Cases the magnitude datapath would get wrong are answered directly at acceptance.
    assign w_div_zero = w_is_div && (bus.rs2_val == '0);
    assign w_div_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (bus.rs1_val == W_MIN) && (bus.rs2_val == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = bus.op[1] ? bus.rs1_val : '1;
        end else if (w_op == OP_DIV) begin
            w_special_res = W_MIN;
        end
    end

    // Shift-add: multiplier sits in the low half of the accumulator and retires one bit per step.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;

    mdu_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (r_state == CALC),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quot_nxt (w_quot_nxt),
        .o_rem_nxt  (w_rem_nxt)
    );

    always_comb begin
        w_calc_res = '0;
        case (r_op)
            OP_MUL:                       w_calc_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_calc_res = r_neg_q ? -w_quot_nxt : w_quot_nxt;
            default:                      w_calc_res = r_neg_r ? -w_rem_nxt : w_rem_nxt;
        endcase
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa;
    logic [2*XLEN-1:0] w_fb;
    logic [2*XLEN-1:0] w_fprod;
    logic [XLEN-1:0]   w_fast_res;

    // Sign-extended operands make a plain modulo-2^64 product correct for every signedness mix.
    assign w_fa       = {{XLEN{w_a_neg}}, bus.rs1_val};
    assign w_fb       = {{XLEN{w_b_neg}}, bus.rs2_val};
    assign w_fprod    = w_fa * w_fb;
    assign w_fast_res = (w_op == OP_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MUL;
            r_rd    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_we3   <= 1'b0;
            r_add3  <= '0;
            r_wd3   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_we3   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_rd    <= bus.rd_in;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_acc   <= {{XLEN{1'b0}}, w_b_mag};
                        r_mcand <= w_a_mag;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (w_special) begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                            r_we3   <= (bus.rd_in != 5'd0);
                            r_add3  <= bus.rd_in;
                            r_wd3   <= w_special_res;
`ifdef MDU_FAST_MUL_EN
                        end else if (!w_is_div) begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                            r_we3   <= (bus.rd_in != 5'd0);
                            r_add3  <= bus.rd_in;
                            r_wd3   <= w_fast_res;
`endif
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(ITER - 1)) begin
                            r_state <= DONE;
                            r_cnt   <= '0;
                            r_valid <= 1'b1;
                            r_we3   <= (r_rd != 5'd0);
                            r_add3  <= r_rd;
                            r_wd3   <= w_calc_res;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.valid = r_valid;
    assign bus.we3   = r_we3;
    assign bus.add3  = r_add3;
    assign bus.wd3   = r_wd3;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_wd3;
    int          nv;

    mdu_iter_if bus();

    mdu_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; res = p[31:0]; end
            3'd1: begin p = sa * sb; res = p[63:32]; end
            3'd2: begin p = sa * ub; res = p[63:32]; end
            3'd3: begin p = ua * ub; res = p[63:32]; end
            3'd4: begin
                if (b == 0) res = 32'hFFFFFFFF;
                else begin p = sa / sb; res = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) res = 32'hFFFFFFFF;
                else begin p = ua / ub; res = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) res = a;
                else begin p = sa % sb; res = p[31:0]; end
            end
            default: begin
                if (b == 0) res = a;
                else begin p = ua % ub; res = p[31:0]; end
            end
        endcase
        return res;
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return 33;
        end
`ifdef MDU_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    task automatic count_valids(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bus.valid === 1'b1) cnt++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit spam, input string tag);
        logic [31:0] exp_wd;
        int          exp_lat;
        int          lat;
        int          cnt;
        exp_wd  = ref_mdu(op, a, b);
        exp_lat = exp_latency(op, a, b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
        tick();
        bus.start   = spam;
        bus.op      = 3'($urandom_range(0, 7));
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        bus.rd_in   = 5'($urandom);
        lat = 1;
        while (bus.valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
            bus.op      = 3'($urandom_range(0, 7));
            bus.rs1_val = $urandom;
            bus.rs2_val = $urandom;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_wd3"}, bus.wd3, exp_wd);
        check({tag, "_add3"}, 32'(bus.add3), 32'(rd));
        check({tag, "_we3"}, 32'(bus.we3), 32'(rd != 5'd0));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        last_wd3 = exp_wd;
        tick();
        check({tag, "_valid_once"}, 32'(bus.valid), 32'd0);
        check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
        if (spam) begin
            count_valids(40, cnt);
            check({tag, "_no_extra_valid"}, 32'(cnt), 32'd0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.op      = 3'd0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd_in   = '0;
        last_wd3    = '0;
        repeat (2) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_we3", 32'(bus.we3), 32'd0);
        check("rst_add3", 32'(bus.add3), 32'd0);
        check("rst_wd3", bus.wd3, 32'd0);
        rst = 1'b0;
        tick();

        run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5, 1'b0, "mul_7x-3");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b0, "mulhu_max");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b0, "mulh_m1");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b0, "mulhsu_m1");
        run_op(3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd3, 1'b0, "div_-7_2");
        run_op(3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd4, 1'b0, "rem_-7_2");
        run_op(3'd5, 32'd100, 32'd0, 5'd6, 1'b0, "divu_by0");
        run_op(3'd7, 32'd100, 32'd0, 5'd6, 1'b0, "remu_by0");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b0, "rem_ovf");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b0, "div_ovf");
        run_op(3'd5, 32'd20, 32'd3, 5'd0, 1'b1, "divu_rd0_busy");

        // Flush mid-CALC, then a start that arrives together with flush must be rejected.
        bus.start   = 1'b1;
        bus.op      = 3'd0;
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        bus.rd_in   = 5'd12;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_valid", 32'(bus.valid), 32'd0);
        check("flush_wd3_hold", bus.wd3, last_wd3);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_beats_start", 32'(bus.busy), 32'd0);
        count_valids(40, nv);
        check("flush_no_valid", 32'(nv), 32'd0);
        run_op(3'd0, 32'h12345678, 32'h9ABCDEF0, 5'd12, 1'b0, "mul_after_flush");

        // Reset in the middle of an iterative divide.
        bus.start   = 1'b1;
        bus.op      = 3'd5;
        bus.rs1_val = 32'd1000;
        bus.rs2_val = 32'd7;
        bus.rd_in   = 5'd8;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        check("midrst_we3", 32'(bus.we3), 32'd0);
        check("midrst_add3", 32'(bus.add3), 32'd0);
        check("midrst_wd3", bus.wd3, 32'd0);
        count_valids(40, nv);
        check("midrst_no_valid", 32'(nv), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) ra = 32'($urandom_range(0, 50));
            run_op(rop, ra, rb, 5'($urandom), 1'b0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
